vec_writeback: RTL and testbench
================================

// Module: vec_writeback
// PURPOSE
//  Vector writeback stage. Feeds the vector register file in the decode stage.
//  Takes whole-register results from the vector ALU (valid/ready handshake).
//  Takes vector load data as MEM_W-bit beats from the memory stage and
//  assembles them into one VLEN-bit register value.
//  Drives a registered, single-cycle write pulse (wb_en/wb_rd/wb_data) that
//  the register file samples on the following negedge.
// PARAMETERS
//  VLEN   256  vector register width, bits
//  MEM_W  32   load beat width, bits; VLEN % MEM_W == 0
//  BEATS  (localparam) VLEN/MEM_W beats per load; counter width $clog2(BEATS)
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high
//  alu_valid      in   1      ALU result present
//  alu_ready      out  1      stage accepts ALU result this cycle
//  alu_rd         in   5      ALU destination vreg
//  alu_data       in   VLEN   ALU result
//  ld_start       in   1      begin a vector load; captures ld_rd
//  ld_rd          in   5      load destination vreg
//  ld_beat_valid  in   1      ld_beat_data valid this cycle
//  ld_beat_data   in   MEM_W  load beat; beat k maps to bits [k*MEM_W +: MEM_W]
//  ld_busy        out  1      load in progress or awaiting commit
//  wb_en          out  1      register file write enable (1-cycle pulse)
//  wb_rd          out  5      write destination
//  wb_data        out  VLEN   write data
//  err_beat       out  1      1-cycle pulse: protocol violation, input dropped
// BEHAVIOUR
//  Reset (async): state=IDLE, beat count=0, assembly buffer=0.
//   Outputs: wb_en=0, wb_rd=0, wb_data=0, err_beat=0, ld_busy=0, alu_ready=1.
//   Reset mid-load discards the partial load; no writeback is issued.
//  FSM states: IDLE, LOAD, COMMIT.
//   IDLE  : ld_start -> LOAD; latch ld_rd; count=0.
//   LOAD  : each ld_beat_valid writes buffer[count*MEM_W +: MEM_W] and
//           increments count. Gaps between beats are allowed.
//           The beat with count==BEATS-1 -> COMMIT.
//   COMMIT: one cycle. Registers wb_data=buffer, wb_rd=latched rd,
//           wb_en=(rd!=0); count=0; -> IDLE.
//  ld_busy = (state != IDLE). alu_ready = (state != COMMIT), combinational.
//  ALU path:
//   alu_valid && alu_ready at edge N -> at N+1 wb_data=alu_data, wb_rd=alu_rd,
//   wb_en=(alu_rd!=0). Latency 1. Throughput 1/cycle outside COMMIT.
//   In COMMIT the ALU is stalled; the source holds alu_valid/alu_rd/alu_data.
//  ALU transfers are accepted in IDLE and LOAD. Load assembly proceeds in
//  parallel; the only contention point is the COMMIT cycle.
//  rd==0 on either path: data and rd still register, but wb_en stays 0
//  (v0 is never written).
//  wb_rd/wb_data hold their last values while wb_en=0. wb_en never stays
//  high for 2 cycles from a single source event.
//  Errors (err_beat pulses 1 cycle at the next edge; state unchanged):
//   - ld_beat_valid in IDLE or COMMIT: beat dropped.
//   - ld_start in LOAD or COMMIT: ignored; the current load continues.
//  Simultaneous ld_start and ld_beat_valid in IDLE: start is taken, beat is
//  flagged as an error (beats are counted only from the cycle after start).
// TESTING
//  1 Assert reset, then release -> wb_en=0, wb_rd=0, wb_data=0, ld_busy=0,
//    alu_ready=1, err_beat=0.
//  2 alu_valid=1, alu_rd=3, alu_data={8{32'hA5A5_0003}} for 1 cycle ->
//    next cycle wb_en=1, wb_rd=3, data matches; following cycle wb_en=0.
//  3 alu_valid=1, alu_rd=0 -> wb_en stays 0; wb_rd=0 registered.
//  4 ld_start with ld_rd=5; 8 beats 32'h1111_1111*k (k=0..7), 2-cycle gap
//    after beat 3 -> wb_en=1 exactly 1 cycle after beat 7, wb_rd=5, bits
//    [k*32+:32]=32'h1111_1111*k. An ALU request held in the COMMIT cycle is
//    accepted the next cycle, and its writeback follows.
//  5 Load rd=7: assert reset after 4 beats, then run a fresh load rd=7 with
//    beats 32'hC0DE_000k -> no writeback from the first load; the second
//    load writes only new data.
//  6 ld_beat_valid in IDLE; ld_start during LOAD -> one err_beat pulse each,
//    no wb_en, and the in-flight load completes with the correct data.

Source files
------------

// File: rtl/vec_writeback.sv
// Vector writeback stage: merges whole-register ALU results with beat-assembled
// vector loads into one registered register-file write pulse.
module vec_writeback #(
  parameter int VLEN  = 256,
  parameter int MEM_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [VLEN-1:0]  alu_data,
  input  logic             ld_start,
  input  logic [4:0]       ld_rd,
  input  logic             ld_beat_valid,
  input  logic [MEM_W-1:0] ld_beat_data,
  output logic             ld_busy,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [VLEN-1:0]  wb_data,
  output logic             err_beat
);
  localparam int BEATS = VLEN / MEM_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                        r_state, w_state_nx;
  logic [CW-1:0]                 r_cnt, w_cnt_nx;
  logic [4:0]                    r_rd, w_rd_nx;
  logic [BEATS-1:0][MEM_W-1:0]   r_buf;
  logic                          w_beat_wr;
  logic                          r_wb_en, w_wb_en_nx;
  logic [4:0]                    r_wb_rd, w_wb_rd_nx;
  logic [VLEN-1:0]               r_wb_data, w_wb_data_nx;
  logic                          r_err, w_err_nx;

  assign ld_busy   = (r_state != IDLE);
  assign alu_ready = (r_state != COMMIT);
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign err_beat  = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rd      <= w_rd_nx;
      r_wb_en   <= w_wb_en_nx;
      r_wb_rd   <= w_wb_rd_nx;
      r_wb_data <= w_wb_data_nx;
      r_err     <= w_err_nx;
    end
  end

  // One slice register per beat; only the slice selected by the count loads.
  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                               r_buf[g] <= '0;
      else if (w_beat_wr && r_cnt == CW'(g))   r_buf[g] <= ld_beat_data;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_rd_nx      = r_rd;
    w_beat_wr    = 1'b0;
    w_err_nx     = 1'b0;
    w_wb_en_nx   = 1'b0;
    w_wb_rd_nx   = r_wb_rd;
    w_wb_data_nx = r_wb_data;
    case (r_state)
      IDLE: begin
        w_err_nx = ld_beat_valid;
        if (ld_start) begin
          w_state_nx = LOAD;
          w_rd_nx    = ld_rd;
          w_cnt_nx   = '0;
        end
      end
      LOAD: begin
        w_err_nx = ld_start;
        if (ld_beat_valid) begin
          w_beat_wr = 1'b1;
          w_cnt_nx  = r_cnt + 1'b1;
          if (r_cnt == CW'(BEATS - 1)) w_state_nx = COMMIT;
        end
      end
      COMMIT: begin
        w_err_nx   = ld_beat_valid | ld_start;
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
    // COMMIT owns the write port; the ALU is stalled by alu_ready then.
    if (r_state == COMMIT) begin
      w_wb_en_nx   = (r_rd != 5'd0);
      w_wb_rd_nx   = r_rd;
      w_wb_data_nx = r_buf;
    end else if (alu_valid) begin
      w_wb_en_nx   = (alu_rd != 5'd0);
      w_wb_rd_nx   = alu_rd;
      w_wb_data_nx = alu_data;
    end
  end
endmodule

// File: tb/tb_vec_writeback.sv
// Bench for vec_writeback: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model.
module tb_vec_writeback;
  localparam int VLEN  = 256;
  localparam int MEM_W = 32;
  localparam int BEATS = VLEN / MEM_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_valid, alu_ready;
  logic [4:0]       alu_rd;
  logic [VLEN-1:0]  alu_data;
  logic             ld_start;
  logic [4:0]       ld_rd;
  logic             ld_beat_valid;
  logic [MEM_W-1:0] ld_beat_data;
  logic             ld_busy, wb_en, err_beat;
  logic [4:0]       wb_rd;
  logic [VLEN-1:0]  wb_data;

  int errors = 0;
  int checks = 0;

  // model: load in progress, beats collected so far, commit owed next edge
  bit               m_loading, m_commit;
  logic [4:0]       m_rd;
  logic [MEM_W-1:0] m_beats[$];
  logic [4:0]       e_rd;
  logic [VLEN-1:0]  e_data;

  vec_writeback #(.VLEN(VLEN), .MEM_W(MEM_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_start(ld_start), .ld_rd(ld_rd), .ld_beat_valid(ld_beat_valid),
    .ld_beat_data(ld_beat_data), .ld_busy(ld_busy),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err_beat(err_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    ld_start = 0; ld_rd = 0; ld_beat_valid = 0; ld_beat_data = '0;
  endtask

  // Advance one clock: predict from current inputs, then check after the edge.
  task automatic cycle();
    logic e_en, e_err;
    logic [VLEN-1:0] packed_v;
    chk("ld_busy", VLEN'(ld_busy), VLEN'(m_loading || m_commit));
    chk("alu_ready", VLEN'(alu_ready), VLEN'(!m_commit));
    e_en = 0; e_err = 0;
    if (m_commit) begin
      packed_v = '0;
      foreach (m_beats[k]) packed_v[k*MEM_W +: MEM_W] = m_beats[k];
      e_en = (m_rd != 0); e_rd = m_rd; e_data = packed_v;
      e_err = ld_beat_valid || ld_start;
      m_commit = 0; m_beats.delete();
    end else begin
      if (alu_valid) begin
        e_en = (alu_rd != 0); e_rd = alu_rd; e_data = alu_data;
      end
      if (m_loading) begin
        e_err = ld_start;
        if (ld_beat_valid) m_beats.push_back(ld_beat_data);
        if (m_beats.size() == BEATS) begin m_loading = 0; m_commit = 1; end
      end else begin
        e_err = ld_beat_valid;
        if (ld_start) begin m_loading = 1; m_rd = ld_rd; m_beats.delete(); end
      end
    end
    @(posedge clk); #1;
    chk("wb_en", VLEN'(wb_en), VLEN'(e_en));
    chk("err_beat", VLEN'(err_beat), VLEN'(e_err));
    chk("wb_rd", VLEN'(wb_rd), VLEN'(e_rd));
    chk("wb_data", wb_data, e_data);
  endtask

  task automatic do_reset();
    quiet();
    #3 reset = 1;
    m_loading = 0; m_commit = 0; m_beats.delete(); e_rd = 0; e_data = '0;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_wb_en", VLEN'(wb_en), '0);
    chk("rst_wb_rd", VLEN'(wb_rd), '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_err", VLEN'(err_beat), '0);
    chk("rst_busy", VLEN'(ld_busy), '0);
    chk("rst_ready", VLEN'(alu_ready), VLEN'(1));
  endtask

  task automatic run_load(input logic [4:0] rd, input logic [MEM_W-1:0] base);
    ld_start = 1; ld_rd = rd; cycle(); ld_start = 0;
    for (int k = 0; k < BEATS; k++) begin
      ld_beat_valid = 1; ld_beat_data = base + MEM_W'(k); cycle();
    end
    ld_beat_valid = 0; cycle(); cycle();
  endtask

  initial begin
    logic [MEM_W-1:0] pat;
    pat = 32'h1111_1111;
    reset = 0;
    quiet();
    do_reset();

    // ALU write to v3, then idle
    alu_valid = 1; alu_rd = 3; alu_data = {8{32'hA5A5_0003}}; cycle();
    quiet(); cycle();
    // ALU write to v0: data registers, no enable
    alu_valid = 1; alu_rd = 0; alu_data = {8{32'h0BAD_F00D}}; cycle();
    quiet(); cycle();

    // Load to v5 with a gap after beat 3; ALU request held across COMMIT
    ld_start = 1; ld_rd = 5; cycle(); ld_start = 0;
    for (int k = 0; k < BEATS; k++) begin
      ld_beat_valid = 1; ld_beat_data = pat * MEM_W'(k); cycle();
      if (k == 3) begin ld_beat_valid = 0; cycle(); cycle(); end
    end
    ld_beat_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = {8{32'h9999_0009}};
    cycle();   // COMMIT: load writes, ALU stalled
    cycle();   // ALU accepted
    quiet(); cycle();

    // Reset mid-load discards it; fresh load writes only new data
    ld_start = 1; ld_rd = 7; cycle(); ld_start = 0;
    for (int k = 0; k < 4; k++) begin
      ld_beat_valid = 1; ld_beat_data = 32'hDEAD_0000 + MEM_W'(k); cycle();
    end
    do_reset();
    cycle();
    run_load(5'd7, 32'hC0DE_0000);

    // Protocol errors: stray beat in IDLE, ld_start mid-load
    ld_beat_valid = 1; ld_beat_data = 32'hFFFF_FFFF; cycle();
    quiet();
    ld_start = 1; ld_rd = 4; cycle(); ld_start = 0;
    for (int k = 0; k < BEATS; k++) begin
      if (k == 2) begin ld_beat_valid = 0; ld_start = 1; ld_rd = 12; cycle(); ld_start = 0; end
      ld_beat_valid = 1; ld_beat_data = 32'h4444_0000 + MEM_W'(k); cycle();
    end
    quiet(); cycle(); cycle();
    // Start and beat together in IDLE: start taken, beat flagged
    ld_start = 1; ld_rd = 6; ld_beat_valid = 1; ld_beat_data = 32'h7777_7777; cycle();
    quiet();
    for (int k = 0; k < BEATS; k++) begin
      ld_beat_valid = 1; ld_beat_data = 32'h6666_0000 + MEM_W'(k); cycle();
    end
    quiet(); cycle(); cycle();

    // Random traffic; the ALU source holds its request while stalled
    for (int n = 0; n < 600; n++) begin
      if (!m_commit || !alu_valid) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 31));
        for (int w = 0; w < VLEN / 32; w++) alu_data[w*32 +: 32] = $urandom;
      end
      ld_start      = ($urandom_range(0, 9) == 0);
      ld_rd         = 5'($urandom_range(0, 31));
      ld_beat_valid = ($urandom_range(0, 3) != 0);
      ld_beat_data  = $urandom;
      cycle();
    end
    quiet(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
